mem_arbiter: RTL and testbench

Two-master, one-slave memory arbiter placed directly upstream of a single memory port. It lets the CPU data path (from `mmio_decode`'s RAM side) and the DMA engine share one memory port, so that the SoC can run with a single-port RAM instead of `dualport_bram`. Each request is latched and forwarded to the slave as one transaction, and the response is routed back to the master that issued it. Arbitration is round-robin, or fixed priority when configured.

---
 rtl/mem_arbiter.sv | 116 +++++++++++
 tb/tb_mem_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-master, one-slave memory arbiter: round-robin or fixed-priority grant, one
// registered slave transaction per grant, response steered back to the granted master.
module mem_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter bit          FIX_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              m0_mem_req,
    input  logic              m0_mem_we,
    input  logic [ADDR_W-1:0] m0_mem_addr,
    input  logic [DATA_W-1:0] m0_mem_wdata,
    output logic [DATA_W-1:0] m0_mem_rdata,
    output logic              m0_mem_ready,

    input  logic              m1_mem_req,
    input  logic              m1_mem_we,
    input  logic [ADDR_W-1:0] m1_mem_addr,
    input  logic [DATA_W-1:0] m1_mem_wdata,
    output logic [DATA_W-1:0] m1_mem_rdata,
    output logic              m1_mem_ready,

    output logic              s_mem_req,
    output logic              s_mem_we,
    output logic [ADDR_W-1:0] s_mem_addr,
    output logic [DATA_W-1:0] s_mem_wdata,
    input  logic [DATA_W-1:0] s_mem_rdata,
    input  logic              s_mem_ready,

    output logic              arb_busy,
    output logic              arb_grant
);

    typedef enum logic [1:0] {StIdle, StBusy0, StBusy1} state_e;

    state_e              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                s_req_q, s_req_d;
    logic                s_we_q, s_we_d;
    logic [ADDR_W-1:0]   s_addr_q, s_addr_d;
    logic [DATA_W-1:0]   s_wdata_q, s_wdata_d;
    logic                win_m1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            s_req_q      <= 1'b0;
            s_we_q       <= 1'b0;
            s_addr_q     <= '0;
            s_wdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            s_req_q      <= s_req_d;
            s_we_q       <= s_we_d;
            s_addr_q     <= s_addr_d;
            s_wdata_q    <= s_wdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        s_req_d      = s_req_q;
        s_we_d       = s_we_q;
        s_addr_d     = s_addr_q;
        s_wdata_d    = s_wdata_q;
        win_m1       = 1'b0;

        case (state_q)
            StIdle: begin
                if (m0_mem_req || m1_mem_req) begin
                    // On a tie, round-robin favours whichever master was not granted last.
                    if (m0_mem_req && m1_mem_req) begin
                        win_m1 = FIX_PRIO ? 1'b0 : ~last_grant_q;
                    end else begin
                        win_m1 = m1_mem_req;
                    end
                    state_d      = win_m1 ? StBusy1 : StBusy0;
                    last_grant_d = win_m1;
                    s_req_d      = 1'b1;
                    s_we_d       = win_m1 ? m1_mem_we    : m0_mem_we;
                    s_addr_d     = win_m1 ? m1_mem_addr  : m0_mem_addr;
                    s_wdata_d    = win_m1 ? m1_mem_wdata : m0_mem_wdata;
                end
            end
            StBusy0, StBusy1: begin
                if (s_mem_ready) begin
                    state_d = StIdle;
                    s_req_d = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                s_req_d = 1'b0;
            end
        endcase
    end

    // A reset edge abandons the transaction, so its completion is never reported.
    assign m0_mem_ready = rst_n && (state_q == StBusy0) && s_mem_ready;
    assign m1_mem_ready = rst_n && (state_q == StBusy1) && s_mem_ready;
    assign m0_mem_rdata = m0_mem_ready ? s_mem_rdata : '0;
    assign m1_mem_rdata = m1_mem_ready ? s_mem_rdata : '0;

    assign s_mem_req   = s_req_q;
    assign s_mem_we    = s_we_q;
    assign s_mem_addr  = s_addr_q;
    assign s_mem_wdata = s_wdata_q;
    assign arb_busy    = (state_q != StIdle);
    assign arb_grant   = last_grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a round-robin instance and a fixed-priority instance
// share one set of inputs and progress in lockstep.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [31:0] s_rdata;
    logic        s_ready;

    logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
    logic        m0_ready, m1_ready, s_req, s_we, busy, grant;
    logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_s_addr, fp_s_wdata;
    logic        fp_m0_ready, fp_m1_ready, fp_s_req, fp_s_we, fp_busy, fp_grant;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .FIX_PRIO(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .m0_mem_req(m0_req), .m0_mem_we(m0_we), .m0_mem_addr(m0_addr),
        .m0_mem_wdata(m0_wdata), .m0_mem_rdata(m0_rdata), .m0_mem_ready(m0_ready),
        .m1_mem_req(m1_req), .m1_mem_we(m1_we), .m1_mem_addr(m1_addr),
        .m1_mem_wdata(m1_wdata), .m1_mem_rdata(m1_rdata), .m1_mem_ready(m1_ready),
        .s_mem_req(s_req), .s_mem_we(s_we), .s_mem_addr(s_addr), .s_mem_wdata(s_wdata),
        .s_mem_rdata(s_rdata), .s_mem_ready(s_ready),
        .arb_busy(busy), .arb_grant(grant)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .FIX_PRIO(1'b1)) u_dut_fp (
        .clk(clk), .rst_n(rst_n),
        .m0_mem_req(m0_req), .m0_mem_we(m0_we), .m0_mem_addr(m0_addr),
        .m0_mem_wdata(m0_wdata), .m0_mem_rdata(fp_m0_rdata), .m0_mem_ready(fp_m0_ready),
        .m1_mem_req(m1_req), .m1_mem_we(m1_we), .m1_mem_addr(m1_addr),
        .m1_mem_wdata(m1_wdata), .m1_mem_rdata(fp_m1_rdata), .m1_mem_ready(fp_m1_ready),
        .s_mem_req(fp_s_req), .s_mem_we(fp_s_we), .s_mem_addr(fp_s_addr),
        .s_mem_wdata(fp_s_wdata), .s_mem_rdata(s_rdata), .s_mem_ready(s_ready),
        .arb_busy(fp_busy), .arb_grant(fp_grant)
    );

    // Inputs change 1 time unit after the rising edge; checks follow 3 units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s_ready = 1'b1; s_rdata = 32'hFFFF_FFFF;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h44; m0_wdata = 32'h55;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h66; m1_wdata = 32'h77;
        tick(); tick(); settle();
        n_cmp++; if (s_req !== 1'b0) begin n_err++; $display("FAIL reset_s_req got %0h want 0", s_req); end
        n_cmp++; if (s_we !== 1'b0) begin n_err++; $display("FAIL reset_s_we got %0h want 0", s_we); end
        n_cmp++; if (s_addr !== 32'h0) begin n_err++; $display("FAIL reset_s_addr got %h want 0", s_addr); end
        n_cmp++; if (s_wdata !== 32'h0) begin n_err++; $display("FAIL reset_s_wdata got %h want 0", s_wdata); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0h want 0", busy); end
        n_cmp++; if (grant !== 1'b1) begin n_err++; $display("FAIL reset_grant got %0h want 1", grant); end
        n_cmp++; if (m0_ready !== 1'b0 || m1_ready !== 1'b0) begin
            n_err++; $display("FAIL reset_ready got %0h%0h want 00", m0_ready, m1_ready); end
        rst_n = 1'b1; s_ready = 1'b0; s_rdata = 32'h0;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0;
    endtask

    task automatic test_single_read();
        tick();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h100;
        settle();
        n_cmp++; if (s_req !== 1'b0) begin n_err++; $display("FAIL rd_req_cycleN got %0h want 0", s_req); end
        tick(); settle();
        n_cmp++; if (s_req !== 1'b1) begin n_err++; $display("FAIL rd_req_cycleN1 got %0h want 1", s_req); end
        n_cmp++; if (s_addr !== 32'h100) begin n_err++; $display("FAIL rd_addr got %h want 100", s_addr); end
        n_cmp++; if (s_we !== 1'b0) begin n_err++; $display("FAIL rd_we got %0h want 0", s_we); end
        n_cmp++; if (grant !== 1'b0) begin n_err++; $display("FAIL rd_grant got %0h want 0", grant); end
        n_cmp++; if (m0_ready !== 1'b0 || m0_rdata !== 32'h0) begin
            n_err++; $display("FAIL rd_early_ready got %0h/%h want 0/0", m0_ready, m0_rdata); end
        tick();
        s_ready = 1'b1; s_rdata = 32'hDEAD_BEEF;
        settle();
        n_cmp++; if (m0_ready !== 1'b1) begin n_err++; $display("FAIL rd_m0_ready got %0h want 1", m0_ready); end
        n_cmp++; if (m0_rdata !== 32'hDEAD_BEEF) begin
            n_err++; $display("FAIL rd_m0_rdata got %h want deadbeef", m0_rdata); end
        n_cmp++; if (m1_ready !== 1'b0 || m1_rdata !== 32'h0) begin
            n_err++; $display("FAIL rd_m1_quiet got %0h/%h want 0/0", m1_ready, m1_rdata); end
        tick();
        s_ready = 1'b0; s_rdata = 32'h0; m0_req = 1'b0;
        settle();
        n_cmp++; if (m0_ready !== 1'b0) begin n_err++; $display("FAIL rd_ready_width got %0h want 0", m0_ready); end
        n_cmp++; if (s_req !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL rd_done got req %0h busy %0h want 0 0", s_req, busy); end
        n_cmp++; if (m1_ready !== 1'b0) begin n_err++; $display("FAIL rd_m1_ready got %0h want 0", m1_ready); end
    endtask

    task automatic test_tie_after_reset();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h200; m1_wdata = 32'h1234_5678;
        tick();
        s_ready = 1'b1; s_rdata = 32'hAAAA_0001;
        settle();
        n_cmp++; if (grant !== 1'b0) begin n_err++; $display("FAIL tie_first_grant got %0h want 0", grant); end
        n_cmp++; if (s_addr !== 32'h10 || s_we !== 1'b0) begin
            n_err++; $display("FAIL tie_m0_on_bus got %h/%0h want 10/0", s_addr, s_we); end
        n_cmp++; if (m0_ready !== 1'b1 || m1_ready !== 1'b0) begin
            n_err++; $display("FAIL tie_m0_done got %0h%0h want 10", m0_ready, m1_ready); end
        tick();
        s_ready = 1'b0; m0_req = 1'b0;
        settle();
        n_cmp++; if (s_req !== 1'b0 || s_addr !== 32'h10) begin
            n_err++; $display("FAIL tie_bubble got %0h/%h want 0/10", s_req, s_addr); end
        tick();
        s_ready = 1'b1; s_rdata = 32'h0;
        settle();
        n_cmp++; if (grant !== 1'b1) begin n_err++; $display("FAIL tie_second_grant got %0h want 1", grant); end
        n_cmp++; if (s_addr !== 32'h200 || s_we !== 1'b1 || s_wdata !== 32'h1234_5678) begin
            n_err++; $display("FAIL tie_m1_write got %h/%0h/%h want 200/1/12345678",
                              s_addr, s_we, s_wdata); end
        n_cmp++; if (m1_ready !== 1'b1 || m0_ready !== 1'b0) begin
            n_err++; $display("FAIL tie_m1_done got %0h%0h want 01", m0_ready, m1_ready); end
        tick();
        s_ready = 1'b0; m1_req = 1'b0; m1_we = 1'b0;
        settle();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL tie_idle got %0h want 0", busy); end
    endtask

    // Round-robin and fixed-priority instances both run here, sharing the same stimulus.
    task automatic test_contention();
        logic exp_g;
        tick();
        m0_req = 1'b1; m0_addr = 32'hA0; m1_req = 1'b1; m1_addr = 32'hB0;
        for (int i = 0; i < 6; i++) begin
            exp_g = (i % 2 == 1);
            tick();
            s_ready = 1'b1; s_rdata = 32'h100 + i;
            settle();
            n_cmp++; if (grant !== exp_g) begin
                n_err++; $display("FAIL rr_grant[%0d] got %0h want %0h", i, grant, exp_g); end
            n_cmp++; if (m0_ready !== !exp_g || m1_ready !== exp_g) begin
                n_err++; $display("FAIL rr_ready[%0d] got %0h%0h want %0h%0h", i,
                                  m0_ready, m1_ready, !exp_g, exp_g); end
            n_cmp++; if (fp_grant !== 1'b0 || fp_m0_ready !== 1'b1 || fp_m1_ready !== 1'b0) begin
                n_err++; $display("FAIL fp_grant[%0d] got %0h rdy %0h%0h want 0 10", i,
                                  fp_grant, fp_m0_ready, fp_m1_ready); end
            tick();
            s_ready = 1'b0;
            settle();
            n_cmp++; if (s_req !== 1'b0 || fp_s_req !== 1'b0) begin
                n_err++; $display("FAIL cont_bubble[%0d] got %0h%0h want 00", i, s_req, fp_s_req); end
        end
        m0_req = 1'b0;
        tick();
        s_ready = 1'b1; s_rdata = 32'h0;
        settle();
        n_cmp++; if (fp_grant !== 1'b1 || fp_m1_ready !== 1'b1 || fp_s_addr !== 32'hB0) begin
            n_err++; $display("FAIL fp_m1_after_drop got %0h/%0h/%h want 1/1/b0",
                              fp_grant, fp_m1_ready, fp_s_addr); end
        tick();
        s_ready = 1'b0; m1_req = 1'b0;
    endtask

    task automatic test_isolation();
        tick();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h300;
        tick();
        m0_addr = 32'h3FC; m0_we = 1'b1; m0_wdata = 32'hCAFE_0000;
        settle();
        n_cmp++; if (s_addr !== 32'h300) begin n_err++; $display("FAIL iso_latch got %h want 300", s_addr); end
        tick(); settle();
        n_cmp++; if (s_addr !== 32'h300 || s_we !== 1'b0 || s_wdata !== 32'h0 || s_req !== 1'b1) begin
            n_err++; $display("FAIL iso_hold got %h/%0h/%h/%0h want 300/0/0/1",
                              s_addr, s_we, s_wdata, s_req); end
        tick();
        s_ready = 1'b1; s_rdata = 32'h55;
        settle();
        n_cmp++; if (m0_ready !== 1'b1 || m0_rdata !== 32'h55) begin
            n_err++; $display("FAIL iso_done got %0h/%h want 1/55", m0_ready, m0_rdata); end
        tick();
        s_ready = 1'b0; m0_req = 1'b0; m0_we = 1'b0;
        tick();
        s_ready = 1'b1; s_rdata = 32'h77;
        settle();
        n_cmp++; if (m0_ready !== 1'b0 || m1_ready !== 1'b0 || m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
            n_err++; $display("FAIL spurious_ready got %0h%0h/%h/%h want 00/0/0",
                              m0_ready, m1_ready, m0_rdata, m1_rdata); end
        tick();
        s_ready = 1'b0;
        settle();
        n_cmp++; if (busy !== 1'b0 || s_req !== 1'b0) begin
            n_err++; $display("FAIL spurious_idle got %0h/%0h want 0/0", busy, s_req); end
    endtask

    task automatic test_reset_mid_txn();
        tick();
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h400;
        tick(); settle();
        n_cmp++; if (grant !== 1'b1 || busy !== 1'b1) begin
            n_err++; $display("FAIL rst_busy1 got %0h/%0h want 1/1", grant, busy); end
        tick();
        rst_n = 1'b0; s_ready = 1'b1; s_rdata = 32'h99; m1_req = 1'b0;
        settle();
        n_cmp++; if (m1_ready !== 1'b0) begin n_err++; $display("FAIL rst_no_ready got %0h want 0", m1_ready); end
        tick();
        rst_n = 1'b1;
        settle();
        n_cmp++; if (s_req !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL rst_abandon got %0h/%0h want 0/0", s_req, busy); end
        n_cmp++; if (m1_ready !== 1'b0) begin n_err++; $display("FAIL rst_late_ready got %0h want 0", m1_ready); end
        tick();
        s_ready = 1'b0;
        m0_req = 1'b1; m0_addr = 32'h500; m1_req = 1'b1; m1_addr = 32'h600;
        tick(); settle();
        n_cmp++; if (grant !== 1'b0 || s_addr !== 32'h500) begin
            n_err++; $display("FAIL rst_tie got %0h/%h want 0/500", grant, s_addr); end
        m0_req = 1'b0; m1_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_tie_after_reset();
        test_contention();
        test_isolation();
        test_reset_mid_txn();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
